// File: rtl/voice_jitter_buffer_if.sv
// voice_jitter_buffer_if
// Bundles the playback buffer's control, write, play and status signals.
//   master : drives enable, in_valid, in_data, sample_req, stat_clr;
//            observes in_ready, out_valid, out_data, fill_level, playing,
//            underrun_cnt, overflow_cnt
//   slave  : the jitter buffer itself (directions reversed)
interface voice_jitter_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 2,
    parameter int ADDR_W     = 10
);
    localparam int FW = DATA_WIDTH * CHANNELS;

    logic              enable;
    logic              in_valid;
    logic [FW-1:0]     in_data;
    logic              in_ready;
    logic              sample_req;
    logic              out_valid;
    logic [FW-1:0]     out_data;
    logic [ADDR_W:0]   fill_level;
    logic              playing;
    logic [15:0]       underrun_cnt;
    logic [15:0]       overflow_cnt;
    logic              stat_clr;

    modport master (
        output enable, in_valid, in_data, sample_req, stat_clr,
        input  in_ready, out_valid, out_data, fill_level, playing,
               underrun_cnt, overflow_cnt
    );

    modport slave (
        input  enable, in_valid, in_data, sample_req, stat_clr,
        output in_ready, out_valid, out_data, fill_level, playing,
               underrun_cnt, overflow_cnt
    );
endinterface

// File: rtl/voice_jitter_buffer.sv
// voice_jitter_buffer
// Playback buffer between the UDP receive path and the I2S DAC transmitter.
// Frames are queued in a FIFO; playback starts once PREFILL frames are
// stored, after which each DAC sample request releases one frame.
// Underruns emit zeros or repeat the last played frame; writes to a full
// FIFO are dropped and counted.
// Ports:
//   sys_clk : sole clock
//   rst_n   : asynchronous active-low reset
//   bus     : slave side of voice_jitter_buffer_if (enable, frame write
//             handshake, sample request / played frame, fill level,
//             playing flag, saturating underrun/overflow counters, clear)
module voice_jitter_buffer #(
    parameter int DATA_WIDTH    = 16,
    parameter int CHANNELS      = 2,
    parameter int ADDR_W        = 10,
    parameter int PREFILL       = 256,
    parameter int UNDERRUN_MODE = 0
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    voice_jitter_buffer_if.slave bus
);
    localparam int FW = DATA_WIDTH * CHANNELS;
    localparam logic [ADDR_W:0] DEPTH_L   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PREFILL_L = PREFILL[ADDR_W:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_PLAY
    } state_t;

    state_t            r_state;
    logic              r_playing;
    logic [FW-1:0]     r_mem [0:(1<<ADDR_W)-1];
    logic [FW-1:0]     r_ramData;
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_fill;
    logic              r_outValid;
    logic              r_outSel;
    logic [FW-1:0]     r_outHold;
    logic              r_hasPop;
    logic [15:0]       r_underCnt;
    logic [15:0]       r_overCnt;

    logic              w_full;
    logic              w_inReady;
    logic              w_write;
    logic              w_overflow;
    logic              w_pop;
    logic              w_underrun;
    logic [FW-1:0]     w_holdVal;

    assign w_full     = (r_fill == DEPTH_L);
    assign w_inReady  = (r_state != ST_IDLE) && !w_full;
    assign w_write    = bus.enable && bus.in_valid && w_inReady;
    // A full FIFO drops the frame even if a pop frees a slot this cycle.
    assign w_overflow = bus.in_valid && (r_state != ST_IDLE) && w_full;
    // Pop/underrun decisions look only at the registered fill level, so a
    // same-cycle write into an empty FIFO still counts as an underrun.
    assign w_pop      = bus.enable && bus.sample_req &&
                        (r_state == ST_PLAY) && (r_fill != '0);
    assign w_underrun = bus.enable && bus.sample_req &&
                        (r_state == ST_PLAY) && (r_fill == '0);
    // The RAM read register only updates on pops, so it doubles as the
    // last-played frame; r_hasPop masks it to zero after a flush.
    assign w_holdVal  = ((UNDERRUN_MODE == 1) && r_hasPop) ? r_ramData : '0;

    // Frame storage with a registered read port, kept reset-free so it
    // maps onto block RAM.
    always_ff @(posedge sys_clk) begin
        if (w_write) begin
            r_mem[r_wrPtr] <= bus.in_data;
        end
        if (w_pop) begin
            r_ramData <= r_mem[r_rdPtr];
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_playing  <= 1'b0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_fill     <= '0;
            r_outValid <= 1'b0;
            r_outSel   <= 1'b0;
            r_outHold  <= '0;
            r_hasPop   <= 1'b0;
            r_underCnt <= '0;
            r_overCnt  <= '0;
        end else begin
            r_outValid <= bus.sample_req;

            if (!bus.enable) begin
                r_state   <= ST_IDLE;
                r_playing <= 1'b0;
                r_wrPtr   <= '0;
                r_rdPtr   <= '0;
                r_fill    <= '0;
                r_outSel  <= 1'b0;
                r_outHold <= '0;
                r_hasPop  <= 1'b0;
            end else begin
                if (w_write) begin
                    r_wrPtr <= r_wrPtr + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + ADDR_W'(1);
                end
                if (w_write && !w_pop) begin
                    r_fill <= r_fill + (ADDR_W+1)'(1);
                end else if (!w_write && w_pop) begin
                    r_fill <= r_fill - (ADDR_W+1)'(1);
                end

                // out_data comes from the RAM register after a pop, otherwise
                // from the held substitute frame.
                if (bus.sample_req) begin
                    if (w_pop) begin
                        r_outSel <= 1'b1;
                        r_hasPop <= 1'b1;
                    end else begin
                        r_outSel  <= 1'b0;
                        r_outHold <= w_holdVal;
                    end
                end

                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_PREFILL;
                    end
                    ST_PREFILL: begin
                        if (r_fill >= PREFILL_L) begin
                            r_state   <= ST_PLAY;
                            r_playing <= 1'b1;
                        end
                    end
                    ST_PLAY: begin
                        if (w_underrun) begin
                            r_state   <= ST_PREFILL;
                            r_playing <= 1'b0;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_playing <= 1'b0;
                    end
                endcase
            end

            // Clear wins over a same-cycle increment.
            if (bus.stat_clr) begin
                r_underCnt <= '0;
                r_overCnt  <= '0;
            end else begin
                if (w_underrun && (r_underCnt != 16'hFFFF)) begin
                    r_underCnt <= r_underCnt + 16'd1;
                end
                if (w_overflow && (r_overCnt != 16'hFFFF)) begin
                    r_overCnt <= r_overCnt + 16'd1;
                end
            end
        end
    end

    assign bus.in_ready     = w_inReady;
    assign bus.out_valid    = r_outValid;
    assign bus.out_data     = r_outSel ? r_ramData : r_outHold;
    assign bus.fill_level   = r_fill;
    assign bus.playing      = r_playing;
    assign bus.underrun_cnt = r_underCnt;
    assign bus.overflow_cnt = r_overCnt;
endmodule

// File: tb/tb_voice_jitter_buffer.sv
// tb_voice_jitter_buffer
// Two buffer instances: A uses the defaults (1024 deep, prefill 256, mute on
// underrun); B is 16 deep, prefill 16, repeat-last on underrun. A queue-based
// model of each buffer is compared against the DUT every cycle, and directed
// literal expectations pin the model at the interesting points.
module tb_voice_jitter_buffer;
    localparam int S_IDLE    = 0;
    localparam int S_PREFILL = 1;
    localparam int S_PLAY    = 2;

    logic clk;
    logic rstN;
    int   passCount;
    int   checkCount;

    voice_jitter_buffer_if #(.DATA_WIDTH(16), .CHANNELS(2), .ADDR_W(10)) busA ();
    voice_jitter_buffer_if #(.DATA_WIDTH(16), .CHANNELS(2), .ADDR_W(4))  busB ();

    voice_jitter_buffer #(
        .DATA_WIDTH(16), .CHANNELS(2), .ADDR_W(10), .PREFILL(256), .UNDERRUN_MODE(0)
    ) dutA (
        .sys_clk(clk),
        .rst_n  (rstN),
        .bus    (busA)
    );

    voice_jitter_buffer #(
        .DATA_WIDTH(16), .CHANNELS(2), .ADDR_W(4), .PREFILL(16), .UNDERRUN_MODE(1)
    ) dutB (
        .sys_clk(clk),
        .rst_n  (rstN),
        .bus    (busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          mState [2];
    logic [31:0] mLast  [2];
    logic [31:0] mOD    [2];
    logic        mOV    [2];
    logic [15:0] mU     [2];
    logic [15:0] mO     [2];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    function automatic int depthOf(input int d);
        return (d == 0) ? 1024 : 16;
    endfunction

    function automatic int prefillOf(input int d);
        return (d == 0) ? 256 : 16;
    endfunction

    function automatic int modeOf(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    function automatic int qSize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [31:0] qPop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic qPush(input int d, input logic [31:0] v);
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic qClear(input int d);
        if (d == 0) q0.delete();
        else        q1.delete();
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mState[d] = S_IDLE;
            mLast[d]  = 32'd0;
            mOD[d]    = 32'd0;
            mOV[d]    = 1'b0;
            mU[d]     = 16'd0;
            mO[d]     = 16'd0;
            qClear(d);
        end
    endtask

    task automatic modelStep(input int d, input logic en, input logic iv,
                             input logic [31:0] din, input logic sreq, input logic clr);
        int          sz;
        int          nxt;
        logic        ovf;
        logic        wr;
        logic        und;
        logic [31:0] od;
        sz  = qSize(d);
        nxt = mState[d];
        ovf = 1'b0;
        wr  = 1'b0;
        und = 1'b0;
        od  = mOD[d];
        if (mState[d] != S_IDLE && iv) begin
            if (sz == depthOf(d)) ovf = 1'b1;
            else                  wr  = 1'b1;
        end
        if (!en) begin
            qClear(d);
            mLast[d] = 32'd0;
            od       = 32'd0;
            wr       = 1'b0;
            nxt      = S_IDLE;
        end else if (mState[d] == S_IDLE) begin
            if (sreq) od = 32'd0;
            nxt = S_PREFILL;
        end else begin
            if (sreq) begin
                if (mState[d] == S_PLAY && sz > 0) begin
                    od       = qPop(d);
                    mLast[d] = od;
                end else begin
                    od = (modeOf(d) == 1) ? mLast[d] : 32'd0;
                    if (mState[d] == S_PLAY) begin
                        und = 1'b1;
                        nxt = S_PREFILL;
                    end
                end
            end
            if (mState[d] == S_PREFILL && sz >= prefillOf(d)) nxt = S_PLAY;
        end
        if (wr) qPush(d, din);
        if (clr) begin
            mU[d] = 16'd0;
            mO[d] = 16'd0;
        end else begin
            if (und && mU[d] != 16'hFFFF) mU[d] = mU[d] + 16'd1;
            if (ovf && mO[d] != 16'hFFFF) mO[d] = mO[d] + 16'd1;
        end
        mOV[d]    = sreq;
        mOD[d]    = od;
        mState[d] = nxt;
    endtask

    initial modelReset();

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            modelReset();
        end else begin
            modelStep(0, busA.enable, busA.in_valid, busA.in_data, busA.sample_req, busA.stat_clr);
            modelStep(1, busB.enable, busB.in_valid, busB.in_data, busB.sample_req, busB.stat_clr);
        end
    end

    // ---------------- per-cycle comparison ----------------
    task automatic compareDut(input int d);
        logic [77:0] act;
        logic [77:0] exp;
        logic        rdy;
        rdy = (mState[d] != S_IDLE) && (qSize(d) < depthOf(d));
        if (d == 0)
            act = {busA.in_ready, busA.out_valid, busA.out_data, busA.fill_level,
                   busA.playing, busA.underrun_cnt, busA.overflow_cnt};
        else
            act = {busB.in_ready, busB.out_valid, busB.out_data, 6'd0, busB.fill_level,
                   busB.playing, busB.underrun_cnt, busB.overflow_cnt};
        exp = {rdy, mOV[d], mOD[d], 11'(qSize(d)), (mState[d] == S_PLAY), mU[d], mO[d]};
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL cycle_dut%0d t=%0t actual {rdy,ov,data,fill,play,ucnt,ocnt}=%h required=%h",
                      d, $time, act, exp);
    endtask

    always @(negedge clk) begin
        if (rstN) begin
            compareDut(0);
            compareDut(1);
        end
    end

    // ---------------- directed stimulus ----------------
    logic enA;
    logic enB;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input int d, input logic en, input logic iv,
                                 input logic [31:0] din, input logic sreq, input logic clr);
        if (d == 0) enA = en;
        else        enB = en;
        busA.enable     = enA;
        busB.enable     = enB;
        busA.in_valid   = (d == 0) ? iv   : 1'b0;
        busA.in_data    = (d == 0) ? din  : 32'd0;
        busA.sample_req = (d == 0) ? sreq : 1'b0;
        busA.stat_clr   = (d == 0) ? clr  : 1'b0;
        busB.in_valid   = (d == 1) ? iv   : 1'b0;
        busB.in_data    = (d == 1) ? din  : 32'd0;
        busB.sample_req = (d == 1) ? sreq : 1'b0;
        busB.stat_clr   = (d == 1) ? clr  : 1'b0;
        @(negedge clk);
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        enA = 1'b0;
        enB = 1'b0;
        busA.enable = 1'b0; busA.in_valid = 1'b0; busA.in_data = 32'd0;
        busA.sample_req = 1'b0; busA.stat_clr = 1'b0;
        busB.enable = 1'b0; busB.in_valid = 1'b0; busB.in_data = 32'd0;
        busB.sample_req = 1'b0; busB.stat_clr = 1'b0;
        rstN = 1'b1;
        #1 rstN = 1'b0;
        #1;
        checkOutput("reset_fill",     64'(busA.fill_level), 64'd0);
        checkOutput("reset_in_ready", 64'(busA.in_ready),   64'd0);
        checkOutput("reset_playing",  64'(busA.playing),    64'd0);
        checkOutput("reset_out",      64'({busA.out_valid, busA.out_data}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;

        // Prefill release on A
        applyStimulus(0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("prefill_in_ready", 64'(busA.in_ready), 64'd1);
        for (int k = 0; k < 255; k++) applyStimulus(0, 1'b1, 1'b1, 32'(k), 1'b0, 1'b0);
        checkOutput("fill_255",       64'(busA.fill_level), 64'd255);
        checkOutput("playing_at_255", 64'(busA.playing),    64'd0);
        applyStimulus(0, 1'b1, 1'b1, 32'd255, 1'b0, 1'b0);
        checkOutput("fill_256",       64'(busA.fill_level), 64'd256);
        checkOutput("playing_at_256", 64'(busA.playing),    64'd0);
        applyStimulus(0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("playing_after",  64'(busA.playing),    64'd1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
            checkOutput("first_frames", 64'({busA.out_valid, busA.out_data}), {31'd0, 1'b1, 32'(k)});
        end
        checkOutput("fill_253", 64'(busA.fill_level), 64'd253);
        applyStimulus(0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("out_held", 64'({busA.out_valid, busA.out_data}), 64'd2);

        // Underrun, mute mode, on A
        for (int k = 3; k < 255; k++) applyStimulus(0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("fill_1", 64'(busA.fill_level), 64'd1);
        applyStimulus(0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("last_stored", 64'(busA.out_data), 64'd255);
        applyStimulus(0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("underrun_mute",  64'({busA.out_valid, busA.out_data}), {31'd0, 1'b1, 32'd0});
        checkOutput("underrun_cnt_a", 64'(busA.underrun_cnt), 64'd1);
        checkOutput("underrun_state", 64'(busA.playing), 64'd0);
        applyStimulus(0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);

        // Overflow on B
        applyStimulus(1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) applyStimulus(1, 1'b1, 1'b1, 32'(k), 1'b0, 1'b0);
        checkOutput("ovf_fill",     64'(busB.fill_level),   64'd16);
        checkOutput("ovf_in_ready", 64'(busB.in_ready),     64'd0);
        checkOutput("ovf_cnt_4",    64'(busB.overflow_cnt), 64'd4);

        // Full with write and pop together: write dropped
        applyStimulus(1, 1'b1, 1'b1, 32'd50, 1'b1, 1'b0);
        checkOutput("sim_full_data", 64'(busB.out_data),     64'd0);
        checkOutput("sim_full_fill", 64'(busB.fill_level),   64'd15);
        checkOutput("sim_full_ocnt", 64'(busB.overflow_cnt), 64'd5);
        for (int k = 1; k < 8; k++) applyStimulus(1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("fill_8", 64'(busB.fill_level), 64'd8);
        for (int k = 0; k < 12; k++) applyStimulus(1, 1'b1, 1'b1, 32'(100 + k), 1'b1, 1'b0);
        checkOutput("wrap_fill", 64'(busB.fill_level), 64'd8);
        checkOutput("wrap_data", 64'(busB.out_data),   64'd103);

        // Underrun, repeat-last mode, on B
        for (int k = 0; k < 7; k++) applyStimulus(1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("hold_stored", 64'(busB.out_data), 64'd111);
        applyStimulus(1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("hold_repeat",    64'({busB.out_valid, busB.out_data}), {31'd0, 1'b1, 32'd111});
        checkOutput("underrun_cnt_b", 64'(busB.underrun_cnt), 64'd1);
        checkOutput("hold_playing",   64'(busB.playing), 64'd0);

        // Flush mid-PLAY on B
        for (int k = 0; k < 16; k++) applyStimulus(1, 1'b1, 1'b1, 32'(200 + k), 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("refill_playing", 64'(busB.playing), 64'd1);
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("flush_playing", 64'(busB.playing),    64'd0);
        checkOutput("flush_fill",    64'(busB.fill_level), 64'd0);
        checkOutput("flush_data",    64'(busB.out_data),   64'd111 & 64'd0);
        checkOutput("flush_cnts",    64'({busB.underrun_cnt, busB.overflow_cnt}), {32'd0, 16'd1, 16'd5});

        // Overflow saturation and clear priority on B
        applyStimulus(1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) applyStimulus(1, 1'b1, 1'b1, 32'(300 + k), 1'b0, 1'b0);
        for (int k = 0; k < 65540; k++) applyStimulus(1, 1'b1, 1'b1, 32'(k), 1'b0, 1'b0);
        checkOutput("ovf_saturate", 64'(busB.overflow_cnt), 64'hFFFF);
        applyStimulus(1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1);
        checkOutput("clr_priority", 64'({busB.underrun_cnt, busB.overflow_cnt}), 64'd0);

        // Asynchronous reset in the middle of a write on A
        applyStimulus(0, 1'b1, 1'b1, 32'd77, 1'b0, 1'b0);
        checkOutput("pre_reset_fill", 64'(busA.fill_level), 64'd1);
        busA.in_valid = 1'b1;
        busA.in_data  = 32'd78;
        #2 rstN = 1'b0;
        #1;
        checkOutput("areset_a_fill",  64'(busA.fill_level), 64'd0);
        checkOutput("areset_a_stat",  64'({busA.in_ready, busA.playing, busA.out_valid}), 64'd0);
        checkOutput("areset_a_cnt",   64'({busA.underrun_cnt, busA.overflow_cnt}), 64'd0);
        checkOutput("areset_a_data",  64'(busA.out_data), 64'd0);
        checkOutput("areset_b_fill",  64'(busB.fill_level), 64'd0);
        busA.in_valid = 1'b0;
        busA.in_data  = 32'd0;
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 4; k++) applyStimulus(0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/voice_jitter_buffer.md
Name: voice_jitter_buffer

Overview:
- Parametrised playback buffer between the UDP receive path and the I2S DAC transmitter.
- Supersedes the latched read-enable scheme, which plays received samples directly.
- Stores multi-channel sample frames in an internal FIFO. Holds playback until a prefill threshold is reached, then releases one frame per DAC sample request.
- Handles underrun (mute or hold-last) and overflow (drop and count), and reports fill level and error counters for debug/LED logic.

Parameters:
DATA_WIDTH, 16, bits per channel sample
CHANNELS, 2, channels per frame (1..8); frame width FW = DATA_WIDTH*CHANNELS
ADDR_W, 10, log2 of FIFO depth in frames (DEPTH = 2^ADDR_W)
PREFILL, 256, frames required before PLAY (1..DEPTH)
UNDERRUN_MODE, 0, 0 = output zeros on underrun; 1 = repeat last played frame

Ports:
sys_clk  input  1  sole clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  playback enable; low flushes buffer
in_valid  input  1  frame write strobe from UDP receive path
in_data  input  FW  frame; channel 0 in LSBs
in_ready  output  1  high when FIFO not full
sample_req  input  1  one-cycle pulse from DAC side, already in sys_clk domain
out_valid  output  1  one-cycle pulse, frame on out_data
out_data  output  FW  played frame; held between pulses
fill_level  output  ADDR_W+1  frames currently stored
playing  output  1  high in PLAY
underrun_cnt  output  16  saturating underrun event count
overflow_cnt  output  16  saturating dropped-write count
stat_clr  input  1  synchronous clear of both counters

Behaviour:
- Reset values: all pointers, fill_level, counters and out_data = 0; out_valid = 0; playing = 0; in_ready = 0; state = IDLE.
- in_ready = (state != IDLE) && (fill_level < DEPTH), combinational from registered state and count.
- Write accepted when in_valid && in_ready.
- in_valid while full, outside IDLE: frame dropped, overflow_cnt++ (saturate at FFFF). No write occurs even if a pop happens the same cycle.
- in_valid in IDLE: ignored and not counted.
- States:
  - IDLE: enable=0. Pointers and fill_level held at 0. sample_req still produces out_valid with out_data = 0. On enable=1 -> PREFILL next cycle.
  - PREFILL: writes accepted. sample_req produces an underrun-style frame per UNDERRUN_MODE without incrementing underrun_cnt. When registered fill_level >= PREFILL -> PLAY.
  - PLAY: sample_req with fill_level > 0 pops one frame. sample_req with fill_level == 0 -> underrun frame per mode, underrun_cnt++, -> PREFILL.
  - enable=0 in any state -> IDLE next cycle. Buffer flushed, out_data = 0; counters retained.
- Latency: sample_req at cycle t -> out_valid high at t+1 with data. Uses registered RAM read; inference as block RAM is expected.
- Hold-last source (UNDERRUN_MODE=1): last frame actually popped, or 0 if none since flush.
- Simultaneous accepted write and pop: fill_level unchanged; pointers both advance.
- Pop decision uses registered fill_level. Write and sample_req to an empty FIFO in PLAY in the same cycle = underrun; the write is stored.
- Pointers wrap modulo DEPTH. fill_level ranges 0..DEPTH inclusive.
- stat_clr has priority over a same-cycle increment; the counter reads 0.
- Async reset mid-operation returns everything to reset values immediately; the FIFO RAM contents need not be cleared.

Test Plan:
- Prefill release: defaults, enable=1, write 255 frames -> playing=0; 256th frame -> playing=1 the cycle after fill_level=256. Then 3 sample_req pulses -> out_valid at t+1 with frames 0,1,2 in order; fill_level=253.
- Underrun, mode 0: PLAY with 1 frame, 2 sample_req -> first outputs the stored frame. Second outputs 0, underrun_cnt=1, state back to PREFILL (playing=0). Rerun with UNDERRUN_MODE=1 -> second output repeats the stored frame.
- Overflow: ADDR_W=4, PREFILL=16, write 20 frames with no reads -> in_ready=0 at fill 16, overflow_cnt=4. Readback yields frames 0..15 only.
- Simultaneous: full FIFO with in_valid and sample_req in the same cycle -> write dropped, overflow_cnt+1, fill 15. At fill 8 with both -> fill stays 8; order preserved across pointer wrap.
- Flush/reset: drop enable mid-PLAY -> IDLE next cycle, fill_level=0, out_data=0, counters kept. Assert rst_n=0 asynchronously mid-write -> all outputs zero without a clock edge.
- Counters: force 65536 overflows -> overflow_cnt saturates at 16'hFFFF. stat_clr coincident with an overflow -> 0.
